// File: rtl/dcache_ctrl_seq_pkg.sv
// Shared definitions for the dcache maintenance sequencer.
// Holds the LSU opcode/param encodings used by the request classifier,
// the decoded maintenance operation type and the sequencer state encoding.
package dcache_ctrl_seq_pkg;

    localparam logic [2:0] OP_CTRL        = 3'b011;
    localparam logic [3:0] PARAM_INV      = 4'b0000;
    localparam logic [3:0] PARAM_FLUSH    = 4'b0001;
    localparam logic [3:0] PARAM_WAITMSHR = 4'b0010;

    typedef enum logic [1:0] {
        OP_FLUSH,
        OP_INV,
        OP_WAIT
    } op_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_WALK   = 3'd2;
    localparam logic [2:0] ST_WBWAIT = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StDrain  = ST_DRAIN,
        StWalk   = ST_WALK,
        StWbWait = ST_WBWAIT,
        StResp   = ST_RESP
    } state_e;

endpackage

// File: rtl/dcache_walk_cnt.sv
// Two-level set/way counter used to walk every line of the tag array.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - advance one line (way first, set on way wrap)
//   clr       - force back to set 0 / way 0 (has priority over inc)
//   set_idx   - current set index
//   way_idx   - current way index
//   last      - current position is the final line (last set, last way)
module dcache_walk_cnt #(
    parameter int unsigned NUM_SET = 32,
    parameter int unsigned NUM_WAY = 2,
    localparam int unsigned SET_W = $clog2(NUM_SET),
    localparam int unsigned WAY_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [SET_W-1:0] set_idx,
    output logic [WAY_W-1:0] way_idx,
    output logic             last
);

    localparam logic [SET_W-1:0] SET_MAX = SET_W'(NUM_SET - 1);
    localparam logic [WAY_W-1:0] WAY_MAX = WAY_W'(NUM_WAY - 1);

    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic             set_last;
    logic             way_last;

    assign set_last = (set_q == SET_MAX);
    // With a single way this is always true, so every inc moves to the next set.
    assign way_last = (way_q == WAY_MAX);

    always_comb begin
        set_d = set_q;
        way_d = way_q;
        if (clr) begin
            set_d = '0;
            way_d = '0;
        end else if (inc) begin
            if (way_last) begin
                way_d = '0;
                set_d = set_last ? '0 : set_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q <= '0;
            way_q <= '0;
        end else begin
            set_q <= set_d;
            way_q <= way_d;
        end
    end

    assign set_idx = set_q;
    assign way_idx = way_q;
    assign last    = set_last && way_last;

endmodule

// File: rtl/dcache_ctrl_seq.sv
// Cache-maintenance sequencer sitting behind the L1 dcache request classifier.
// Accepts opcode 3'b011 requests (flush / invalidate / wait_mshr), drains the
// MSHRs, walks every set/way issuing one maintenance command per line, waits
// for the write-back buffer on flush and returns one response per request.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/ready/opcode/param/id - maintenance request from the classifier
//   mshr_empty, wb_empty          - level status from MSHR file and WB buffer
//   walk_valid/ready/set/way/flush - per-line command to the tag array
//   rsp_valid/ready/id/err        - completion response
//   busy                          - holds the core pipeline while not idle
module dcache_ctrl_seq
    import dcache_ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_SET = 32,
    parameter int unsigned NUM_WAY = 2,
    parameter int unsigned ID_W    = 8,
    localparam int unsigned SET_W  = $clog2(NUM_SET),
    localparam int unsigned WAY_W  = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [3:0]       req_param,
    input  logic [ID_W-1:0]  req_id,
    input  logic             mshr_empty,
    input  logic             wb_empty,
    output logic             walk_valid,
    input  logic             walk_ready,
    output logic [SET_W-1:0] walk_set,
    output logic [WAY_W-1:0] walk_way,
    output logic             walk_flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic             rsp_err,
    output logic             busy
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             err_q, err_d;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_last;

    dcache_walk_cnt #(
        .NUM_SET(NUM_SET),
        .NUM_WAY(NUM_WAY)
    ) u_walk_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .set_idx(walk_set),
        .way_idx(walk_way),
        .last   (cnt_last)
    );

    assign req_ready  = (state_q == StIdle) && (req_opcode == OP_CTRL);
    assign walk_valid = (state_q == StWalk);
    // Gated by the walk state so the command bus reads all-zero when idle.
    assign walk_flush = walk_valid && (op_q == OP_FLUSH);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        err_d   = err_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    id_d  = req_id;
                    err_d = 1'b0;
                    case (req_param)
                        PARAM_FLUSH: begin
                            op_d    = OP_FLUSH;
                            state_d = StDrain;
                        end
                        PARAM_INV: begin
                            op_d    = OP_INV;
                            state_d = StDrain;
                        end
                        PARAM_WAITMSHR: begin
                            op_d    = OP_WAIT;
                            state_d = StDrain;
                        end
                        default: begin
                            // Unsupported param: answer straight away with an error.
                            op_d    = OP_WAIT;
                            err_d   = 1'b1;
                            state_d = StResp;
                        end
                    endcase
                end
            end
            StDrain: begin
                if (mshr_empty) begin
                    if (op_q == OP_WAIT) begin
                        state_d = StResp;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = StWalk;
                    end
                end
            end
            StWalk: begin
                if (walk_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = (op_q == OP_FLUSH) ? StWbWait : StResp;
                    end
                end
            end
            StWbWait: begin
                if (wb_empty) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OP_FLUSH;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl_seq.sv
// Self-checking bench for dcache_ctrl_seq (4 sets x 2 ways).
module tb_dcache_ctrl_seq;

    localparam int unsigned NS  = 4;
    localparam int unsigned NW  = 2;
    localparam int unsigned IDW = 8;
    localparam int          NHS = NS * NW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [2:0]     req_opcode = 3'b000;
    logic [3:0]     req_param = 4'b0000;
    logic [IDW-1:0] req_id = '0;
    logic           mshr_empty = 1'b1;
    logic           wb_empty = 1'b1;
    logic           walk_valid;
    logic           walk_ready = 1'b1;
    logic [1:0]     walk_set;
    logic [0:0]     walk_way;
    logic           walk_flush;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IDW-1:0] rsp_id;
    logic           rsp_err;
    logic           busy;

    dcache_ctrl_seq #(
        .NUM_SET(NS),
        .NUM_WAY(NW),
        .ID_W   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_param (req_param),
        .req_id    (req_id),
        .mshr_empty(mshr_empty),
        .wb_empty  (wb_empty),
        .walk_valid(walk_valid),
        .walk_ready(walk_ready),
        .walk_set  (walk_set),
        .walk_way  (walk_way),
        .walk_flush(walk_flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one outstanding request, tracked as a list of timed events.
    // kind: 0 flush, 1 invalidate, 2 wait_mshr, 3 illegal param.
    bit pend = 0;
    int m_kind, m_id, acc_cyc, drain_cyc, last_hs_cyc, hs_cnt, rsp_due;
    bit drain_done, wb_done;
    bit rdy_exp, walk_exp, rsp_exp;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_walk_valid", 32'(walk_valid), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_walk_set", 32'(walk_set), 32'd0);
            chk("rst_walk_way", 32'(walk_way), 32'd0);
            chk("rst_walk_flush", 32'(walk_flush), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            pend = 0;
        end else begin
            rdy_exp  = !pend && (req_opcode == 3'b011);
            walk_exp = pend && (m_kind < 2) && drain_done && (cyc > drain_cyc) && (hs_cnt < NHS);
            rsp_exp  = pend && (rsp_due >= 0) && (cyc >= rsp_due);

            chk("busy", 32'(busy), 32'(pend));
            chk("req_ready", 32'(req_ready), 32'(rdy_exp));
            chk("walk_valid", 32'(walk_valid), 32'(walk_exp));
            chk("rsp_valid", 32'(rsp_valid), 32'(rsp_exp));
            if (walk_exp && walk_valid) begin
                chk("walk_set", 32'(walk_set), 32'(hs_cnt / NW));
                chk("walk_way", 32'(walk_way), 32'(hs_cnt % NW));
                chk("walk_flush", 32'(walk_flush), 32'(m_kind == 0));
            end
            if (rsp_exp && rsp_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_err", 32'(rsp_err), 32'(m_kind == 3));
            end

            if (pend) begin
                if (rsp_exp && rsp_ready) begin
                    pend = 0;
                end else begin
                    if (m_kind < 3 && !drain_done && cyc > acc_cyc && mshr_empty) begin
                        drain_done = 1;
                        drain_cyc  = cyc;
                        if (m_kind == 2) rsp_due = cyc + 1;
                    end
                    if (walk_exp && walk_ready) begin
                        hs_cnt++;
                        if (hs_cnt == NHS) begin
                            last_hs_cyc = cyc;
                            if (m_kind == 1) rsp_due = cyc + 1;
                        end
                    end
                    if (m_kind == 0 && hs_cnt == NHS && !wb_done && cyc > last_hs_cyc
                        && wb_empty) begin
                        wb_done = 1;
                        rsp_due = cyc + 1;
                    end
                end
            end else if (req_valid && rdy_exp) begin
                pend       = 1;
                acc_cyc    = cyc;
                m_id       = int'(req_id);
                drain_done = 0;
                wb_done    = 0;
                hs_cnt     = 0;
                rsp_due    = -1;
                case (req_param)
                    4'b0001: m_kind = 0;
                    4'b0000: m_kind = 1;
                    4'b0010: m_kind = 2;
                    default: begin
                        m_kind  = 3;
                        rsp_due = cyc + 1;
                    end
                endcase
            end
        end
    end

    // Issues one request and shapes the status inputs relative to its accept cycle.
    // lat = cycles from accept to first rsp_valid (-1 if it never came).
    task automatic run_req(input logic [3:0] prm, input logic [7:0] id, input int mshr_lo,
                           input int wb_lo, input bit toggle, input int rsp_lo,
                           output int lat);
        int  n;
        int  wbw;
        int  rcnt;
        bit  seen_walk;
        bit  done;
        lat = -1;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_opcode = 3'b011;
        req_param  = prm;
        req_id     = id;
        walk_ready = 1'b1;
        rsp_ready  = 1'b0;
        wb_empty   = 1'b0;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_opcode = 3'b000;
        n = 1; wbw = 0; rcnt = 0; seen_walk = 0; done = 0;
        while (n < 200 && !done) begin
            if (walk_valid) seen_walk = 1;
            else if (seen_walk && busy && !rsp_valid) wbw++;
            mshr_empty = (n > mshr_lo);
            wb_empty   = (wbw > wb_lo);
            walk_ready = toggle ? (n % 2 == 0) : 1'b1;
            if (rsp_valid) begin
                if (lat < 0) lat = n;
                rcnt++;
            end
            rsp_ready = rsp_valid && (rcnt > rsp_lo);
            if (rsp_valid && rsp_ready) done = 1;
            @(posedge clk); #1;
            n++;
        end
        rsp_ready  = 1'b1;
        mshr_empty = 1'b1;
        wb_empty   = 1'b1;
        walk_ready = 1'b1;
    endtask

    initial begin
        int lat;
        int n;
        int r;
        #2 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_rsp_id", 32'(rsp_id), 32'd0);
        chk("init_walk_set", 32'(walk_set), 32'd0);
        rst = 1'b0;

        // wait_mshr with MSHRs busy for 5 cycles
        run_req(4'b0010, 8'h5A, 5, 0, 1'b0, 0, lat);
        chk("lat_wait_mshr", 32'(lat), 32'd7);

        // invalidate, tag array always ready
        run_req(4'b0000, 8'h11, 0, 0, 1'b0, 0, lat);
        chk("lat_invalidate", 32'(lat), 32'd10);

        // flush, walk_ready 1010..., WB buffer busy 3 cycles
        run_req(4'b0001, 8'h22, 0, 3, 1'b1, 0, lat);
        chk("lat_flush_stall", 32'(lat), 32'd21);

        // illegal param, response held 4 cycles
        run_req(4'b0111, 8'h33, 0, 0, 1'b0, 4, lat);
        chk("lat_illegal", 32'(lat), 32'd1);

        // non-maintenance opcode is never accepted
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = 3'b000; req_param = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("other_op_ready", 32'(req_ready), 32'd0);
            chk("other_op_busy", 32'(busy), 32'd0);
        end
        req_valid = 1'b0;

        // reset in the middle of a flush walk
        @(posedge clk); #1;
        req_valid = 1'b1; req_opcode = 3'b011; req_param = 4'b0001; req_id = 8'hC3;
        wb_empty = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_opcode = 3'b000;
        n = 0;
        while (!(walk_valid && walk_set == 2'd2) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_set2", 32'(walk_set), 32'd2);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_walk_valid", 32'(walk_valid), 32'd0);
        chk("abort_walk_set", 32'(walk_set), 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wb_empty = 1'b1;
        run_req(4'b0001, 8'h3C, 0, 0, 1'b0, 0, lat);
        chk("lat_flush_after_rst", 32'(lat), 32'd11);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 599) == 0);
            req_valid  = 1'($urandom_range(0, 1));
            req_opcode = ($urandom_range(0, 3) != 0) ? 3'b011 : 3'($urandom_range(0, 7));
            r = $urandom_range(0, 3);
            req_param  = (r < 3) ? 4'(r) : 4'($urandom_range(0, 15));
            req_id     = 8'($urandom);
            mshr_empty = ($urandom_range(0, 9) < 6);
            wb_empty   = ($urandom_range(0, 9) < 5);
            walk_ready = ($urandom_range(0, 9) < 7);
            rsp_ready  = ($urandom_range(0, 9) < 5);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
